// File: rtl/useq_pkg.sv
// Shared useq definitions: data width, default counter width and the stream byte type.
package useq_pkg;
   localparam int USEQ_DATA_W = 8;
   localparam int USEQ_CNT_W  = 16;

   typedef logic [USEQ_DATA_W-1:0] useq_byte_t;
endpackage

// File: rtl/useq_skid2.sv
// Two-entry skid buffer with valid/ready on both sides and registered outputs.
// Accepts and drains on the same edge at full rate. Ordering is preserved and occupancy is exported.
module useq_skid2
   import useq_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [USEQ_DATA_W-1:0] in_dat,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [USEQ_DATA_W-1:0] out_dat,
   output logic [1:0]             occ
);
   useq_byte_t ent0_q, ent0_d;
   useq_byte_t ent1_q, ent1_d;
   logic [1:0] occ_q, occ_d, occ_pop;
   logic       push, pop;

   assign in_rdy  = (occ_q != 2'd2);
   assign out_vld = (occ_q != 2'd0);
   assign out_dat = ent0_q;
   assign occ     = occ_q;
   assign push    = in_vld & in_rdy;
   assign pop     = out_vld & out_rdy;

   // Entry 0 is always the oldest; a drain shifts entry 1 forward before the new byte lands.
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      occ_pop = occ_q - {1'b0, pop};
      if (pop) begin
         ent0_d = ent1_q;
      end
      if (push) begin
         if (occ_pop == 2'd0) begin
            ent0_d = in_dat;
         end else begin
            ent1_d = in_dat;
         end
      end
      occ_d = occ_pop + {1'b0, push};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end
endmodule

// File: rtl/useq_fifo_host.sv
// Host-side master for the useq FIFO port: one-register TX path, 2-entry RX skid, stall watchdog, traffic counters.
// TX pushes the cycle after accept; RX byte is valid the cycle after the pop; both stall only on useq full/empty or host backpressure.
module useq_fifo_host
   import useq_pkg::*;
#(
   parameter int STALL_CYCLES = 255,
   parameter int CNT_W        = USEQ_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [USEQ_DATA_W-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [USEQ_DATA_W-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   write_fifo,
   output logic [USEQ_DATA_W-1:0] fifo_in,
   input  logic                   fifo_full,
   output logic                   read_fifo,
   input  logic [USEQ_DATA_W-1:0] fifo_out,
   input  logic                   fifo_empty,
   output logic                   tx_stall,
   input  logic                   clr_stall,
   output logic [CNT_W-1:0]       tx_count,
   output logic [CNT_W-1:0]       rx_count
);
   localparam int              SC_W      = $clog2(STALL_CYCLES + 1);
   localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_CYCLES);

   logic             hold_valid_q, hold_valid_d;
   useq_byte_t       hold_data_q, hold_data_d;
   logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic             tx_stall_q, tx_stall_d;
   logic [CNT_W-1:0] tx_count_q, tx_count_d;
   logic [CNT_W-1:0] rx_count_q, rx_count_d;
   logic             tx_acc, src_vld;
   logic [1:0]       rx_occ;
   logic             skid_rdy_unused;

   assign write_fifo = hold_valid_q & ~fifo_full;
   assign tx_ready   = ~hold_valid_q | write_fifo;
   assign tx_acc     = tx_valid & tx_ready;
   assign fifo_in    = hold_data_q;
   assign tx_stall   = tx_stall_q;
   assign tx_count   = tx_count_q;
   assign rx_count   = rx_count_q;

   // Never pop while in reset: the skid is held empty and the byte would be lost.
   assign src_vld   = ~fifo_empty & ~rst;
   assign read_fifo = src_vld & (rx_occ != 2'd2);

   useq_skid2 u_skid (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (src_vld),
      .in_rdy  (skid_rdy_unused),
      .in_dat  (fifo_out),
      .out_vld (rx_valid),
      .out_rdy (rx_ready),
      .out_dat (rx_data),
      .occ     (rx_occ)
   );

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      if (tx_acc) begin
         hold_valid_d = 1'b1;
         hold_data_d  = tx_data;
      end else if (write_fifo) begin
         hold_valid_d = 1'b0;
      end
   end

   // Watchdog counts blocked cycles; the flag is sticky until clr_stall, which wins over a same-cycle set.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      tx_stall_d  = tx_stall_q;
      if (clr_stall) begin
         stall_cnt_d = '0;
         tx_stall_d  = 1'b0;
      end else if (write_fifo) begin
         stall_cnt_d = '0;
      end else if (hold_valid_q & fifo_full) begin
         if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
         if (stall_cnt_d == STALL_MAX) begin
            tx_stall_d = 1'b1;
         end
      end
   end

   always_comb begin
      tx_count_d = tx_count_q + CNT_W'(write_fifo);
      rx_count_d = rx_count_q + CNT_W'(read_fifo);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         stall_cnt_q  <= '0;
         tx_stall_q   <= 1'b0;
         tx_count_q   <= '0;
         rx_count_q   <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         stall_cnt_q  <= stall_cnt_d;
         tx_stall_q   <= tx_stall_d;
         tx_count_q   <= tx_count_d;
         rx_count_q   <= rx_count_d;
      end
   end
endmodule

// File: tb/tb_useq_fifo_host.sv
// Bench for useq_fifo_host against a depth-2 useq FIFO model with registered full/empty flags.
module tb_useq_fifo_host;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data, rx_data, fifo_in, fifo_out;
   logic       tx_valid, tx_ready, rx_valid, rx_ready;
   logic       write_fifo, fifo_full, read_fifo, fifo_empty;
   logic       tx_stall, clr_stall;
   logic [3:0] tx_count, rx_count;

   useq_fifo_host #(.STALL_CYCLES(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .write_fifo (write_fifo),
      .fifo_in    (fifo_in),
      .fifo_full  (fifo_full),
      .read_fifo  (read_fifo),
      .fifo_out   (fifo_out),
      .fifo_empty (fifo_empty),
      .tx_stall   (tx_stall),
      .clr_stall  (clr_stall),
      .tx_count   (tx_count),
      .rx_count   (rx_count)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] inq[$];
   logic [7:0] tx_exp[$];
   logic [7:0] src_mem [0:1023];
   int         src_wr = 0, src_rd = 0, rx_chk = 0;
   int         n_push = 0, n_rx = 0, drain_req = 0;
   bit         drain_en = 1'b0;
   bit         acc_tx = 1'b0;
   logic       s_wr, s_rd, s_txacc, s_rxacc;
   logic [7:0] s_din, s_txd, s_rxd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample the port mid-cycle, then advance the useq model at the edge.
   task automatic tick();
      @(negedge clk);
      s_wr = write_fifo;  s_din = fifo_in;  s_rd = read_fifo;
      s_txacc = tx_valid & tx_ready;  s_txd = tx_data;
      s_rxacc = rx_valid & rx_ready;  s_rxd = rx_data;
      @(posedge clk);
      if (!rst) begin
         if ((drain_en || drain_req > 0) && inq.size() > 0) begin
            void'(inq.pop_front());
            if (drain_req > 0) drain_req--;
         end
         if (s_wr) begin
            n_push++;
            chk("inq_room", 32'(inq.size() < 2), 1);
            chk("tx_expected", 32'(tx_exp.size() > 0), 1);
            if (tx_exp.size() > 0) begin
               chk("tx_order", 32'(s_din), 32'(tx_exp[0]));
               void'(tx_exp.pop_front());
            end
            inq.push_back(s_din);
         end
         if (s_txacc) tx_exp.push_back(s_txd);
         if (s_rd) begin
            chk("rd_nonempty", 32'(src_rd < src_wr), 1);
            src_rd++;
         end
         if (s_rxacc) begin
            chk("rx_order", 32'(s_rxd), 32'(src_mem[rx_chk]));
            rx_chk++;
            n_rx++;
         end
      end
      fifo_full  <= (inq.size() >= 2);
      fifo_empty <= (src_rd >= src_wr);
      fifo_out   <= (src_rd < src_wr) ? src_mem[src_rd] : 8'h00;
      acc_tx = s_txacc;
      #1;
   endtask

   task automatic src_push(input logic [7:0] b);
      src_mem[src_wr] = b;
      src_wr++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tx_exp.delete();
      inq.delete();
      src_rd = src_wr;  rx_chk = src_wr;
      n_push = 0;  n_rx = 0;  drain_req = 0;
      tx_valid = 1'b0;  clr_stall = 1'b0;
      fifo_full <= 1'b0;  fifo_empty <= 1'b1;  fifo_out <= 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic tx_send(input logic [7:0] b);
      bit ok = 1'b0;
      tx_valid = 1'b1;
      tx_data  = b;
      for (int i = 0; i < 64 && !ok; i++) begin
         tick();
         ok = acc_tx;
      end
      chk("tx_accept_timeout", 32'(ok), 1);
   endtask

   task automatic wait_quiet();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (tx_exp.size() == 0 && rx_chk == src_wr) ok = 1'b1;
         else tick();
      end
      chk("quiet_timeout", 32'(ok), 1);
   endtask

   initial begin
      int sent, src_base;
      rst = 1'b1;  tx_valid = 1'b0;  tx_data = 8'h00;  rx_ready = 1'b0;  clr_stall = 1'b0;
      fifo_full = 1'b0;  fifo_empty = 1'b1;  fifo_out = 8'h00;

      // Reset mid-stream with 0xEE held and the RX skid full
      do_reset();
      drain_en = 1'b0;  rx_ready = 1'b0;
      src_push(8'h51);  src_push(8'h52);
      tx_send(8'h01);  tx_send(8'h02);  tx_send(8'hEE);
      tx_valid = 1'b0;
      repeat (2) tick();
      chk("t1_occ_full", 32'(dut.rx_occ), 2);
      chk("t1_held", 32'(tx_ready), 0);
      #2;
      rst = 1'b1;
      tx_exp.delete();
      rx_chk = src_rd;
      #1;
      chk("rst_write_fifo", 32'(write_fifo), 0);
      chk("rst_read_fifo", 32'(read_fifo), 0);
      chk("rst_tx_ready", 32'(tx_ready), 1);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_fifo_in", 32'(fifo_in), 0);
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_tx_stall", 32'(tx_stall), 0);
      chk("rst_tx_count", 32'(tx_count), 0);
      chk("rst_rx_count", 32'(rx_count), 0);
      tick();
      rst = 1'b0;
      drain_en = 1'b1;
      repeat (6) tick();
      chk("t1_no_ee_push", 32'(n_push), 2);
      chk("t1_tx_count", 32'(tx_count), 0);

      // TX burst with the model draining every cycle
      do_reset();
      drain_en = 1'b1;  rx_ready = 1'b1;
      tx_send(8'hCC);
      chk("t2_wr_cc", 32'(write_fifo), 1);
      chk("t2_din_cc", 32'(fifo_in), 'hCC);
      tx_send(8'hDD);
      chk("t2_din_dd", 32'(fifo_in), 'hDD);
      tx_valid = 1'b0;
      repeat (4) tick();
      chk("t2_pushes", 32'(n_push), 2);
      chk("t2_tx_count", 32'(tx_count), 2);

      // TX into a full FIFO, watchdog and clear
      do_reset();
      drain_en = 1'b0;
      tx_send(8'h11);  tx_send(8'h22);  tx_send(8'h33);
      tx_valid = 1'b0;
      chk("t3_ready_low", 32'(tx_ready), 0);
      chk("t3_wr_low", 32'(write_fifo), 0);
      chk("t3_held_33", 32'(fifo_in), 'h33);
      repeat (3) tick();
      chk("t3_stall_early", 32'(tx_stall), 0);
      tick();
      chk("t3_stall_set", 32'(tx_stall), 1);
      chk("t3_two_pushes", 32'(n_push), 2);
      clr_stall = 1'b1;
      tick();
      clr_stall = 1'b0;
      chk("t3_stall_clr", 32'(tx_stall), 0);
      drain_req = 1;
      tick();
      chk("t3_wr_after_drain", 32'(write_fifo), 1);
      chk("t3_din_33", 32'(fifo_in), 'h33);
      tick();
      chk("t3_tx_count", 32'(tx_count), 3);
      chk("t3_ready_back", 32'(tx_ready), 1);

      // RX with backpressure
      do_reset();
      drain_en = 1'b1;  rx_ready = 1'b0;
      src_push(8'hA1);  src_push(8'hA2);  src_push(8'hA3);
      tick();
      chk("t4_rd_first", 32'(read_fifo), 1);
      chk("t4_valid_not_yet", 32'(rx_valid), 0);
      tick();
      chk("t4_valid_next", 32'(rx_valid), 1);
      repeat (4) tick();
      chk("t4_two_pops", 32'(rx_count), 2);
      chk("t4_rd_blocked", 32'(read_fifo), 0);
      chk("t4_head_a1", 32'(rx_data), 'hA1);
      rx_ready = 1'b1;
      wait_quiet();
      chk("t4_rx_count", 32'(rx_count), 3);
      chk("t4_delivered", 32'(n_rx), 3);

      // Full duplex
      do_reset();
      drain_en = 1'b1;  rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) src_push(8'(8'h80 + i));
      for (int i = 0; i < 8; i++) tx_send(8'(i));
      tx_valid = 1'b0;
      wait_quiet();
      chk("t5_tx_count", 32'(tx_count), 8);
      chk("t5_rx_count", 32'(rx_count), 8);
      chk("t5_pushes", 32'(n_push), 8);
      chk("t5_delivered", 32'(n_rx), 8);

      // Counter wrap at 4 bits
      do_reset();
      drain_en = 1'b1;
      for (int i = 0; i < 17; i++) tx_send(8'(8'h40 + i));
      tx_valid = 1'b0;
      wait_quiet();
      chk("t6_pushes", 32'(n_push), 17);
      chk("t6_tx_wrap", 32'(tx_count), 1);

      // Random traffic on both paths
      do_reset();
      sent = 0;
      src_base = src_wr;
      for (int i = 0; i < 400; i++) begin
         drain_en  = ($urandom_range(0, 3) != 0);
         rx_ready  = ($urandom_range(0, 2) != 0);
         clr_stall = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 2) != 0 && (src_wr - src_rd) < 4) src_push(8'($urandom));
         if (!tx_valid && $urandom_range(0, 1) == 1) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
         end
         tick();
         if (acc_tx) begin
            sent++;
            tx_valid = 1'b0;
         end
      end
      tx_valid = 1'b0;  clr_stall = 1'b0;  drain_en = 1'b1;  rx_ready = 1'b1;
      wait_quiet();
      chk("rnd_pushes", 32'(n_push), 32'(sent));
      chk("rnd_tx_count", 32'(tx_count), 32'(sent % 16));
      chk("rnd_rx_count", 32'(rx_count), 32'((src_wr - src_base) % 16));
      chk("rnd_delivered", 32'(n_rx), 32'(src_wr - src_base));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/useq_fifo_host.md
# useq_fifo_host

Host-side master for the useq host FIFO port: it drives `write_fifo`/`fifo_in` into the sequencer's inbound FIFO and `read_fifo` out of its outbound FIFO, and presents both directions to the host fabric as valid/ready byte streams. It sits between useq and any host agent (UART bridge, SPI slave, test harness). It adds buffering for full throughput, a transmit stall watchdog and traffic counters.

## Interface
- `STALL_CYCLES`, 255: consecutive cycles the TX path may be blocked by `fifo_full` before `tx_stall` sets. Must be ≥ 1.
- `CNT_W`, 16: width of the traffic counters.
- `clk` input 1: single clock. All state is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `tx_data` input 8: byte to send to useq.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: byte is accepted on an edge where `tx_valid & tx_ready`.
- `rx_data` output 8: byte received from useq.
- `rx_valid` output 1: `rx_data` is valid.
- `rx_ready` input 1: byte is consumed on an edge where `rx_valid & rx_ready`.
- `write_fifo` output 1: push to the useq inbound FIFO.
- `fifo_in` output 8: push data.
- `fifo_full` input 1: useq inbound FIFO is full (registered inside useq).
- `read_fifo` output 1: pop from the useq outbound FIFO.
- `fifo_out` input 8: head of the useq outbound FIFO. Valid while `!fifo_empty`.
- `fifo_empty` input 1: useq outbound FIFO is empty (registered inside useq).
- `tx_stall` output 1: sticky watchdog flag.
- `clr_stall` input 1: clears `tx_stall` and the stall counter.
- `tx_count` output CNT_W: total pushes committed.
- `rx_count` output CNT_W: total pops committed.

## Operation
- **TX path (one holding register)**
  - `hold_valid` and `hold_data` form the holding register.
  - `write_fifo = hold_valid & ~fifo_full`.
  - `fifo_in = hold_data`, held stable while `hold_valid`.
  - `tx_ready = ~hold_valid | write_fifo`.
  - Accepting a byte loads the holding register. A push without a new accept clears `hold_valid`.
- **RX path (2-entry skid buffer, occupancy `occ` 0..2)**
  - `read_fifo = ~fifo_empty & (occ != 2)`.
  - `fifo_out` is captured into the tail on the same edge as the pop.
  - `rx_valid = (occ != 0)`; `rx_data` is the oldest entry.
  - On the same edge, pop-in plus drain-out leaves `occ` unchanged and keeps ordering.
- **Stall watchdog**
  - `stall_cnt` increments each cycle where `hold_valid & fifo_full`.
  - It clears on any push.
  - When it reaches `STALL_CYCLES`, `tx_stall` sets and `stall_cnt` saturates.
  - `clr_stall` has priority over setting in the same cycle.
  - `tx_stall` does not block traffic.
- **Counters**
  - `tx_count` increments on each edge with `write_fifo`.
  - `rx_count` increments on each edge with `read_fifo`.
  - Both wrap modulo 2^CNT_W.
- The TX and RX paths are fully independent. Simultaneous push and pop is legal.

## Timing
- **Reset values:** `write_fifo=0`, `read_fifo=0`, `tx_ready=1`, `rx_valid=0`, `fifo_in=0`, `rx_data=0`, `tx_stall=0`, both counts 0, `occ=0`, `hold_valid=0`.
- **Reset mid-operation:** the held TX byte and the buffered RX bytes are discarded. Bytes already committed to useq stay in useq.
- **TX latency:** byte accepted at edge E, `write_fifo` high in the cycle after E (if not full), committed at edge E+1. Sustained rate is 1 byte/clk while not full.
- **Full:** while `fifo_full`, `write_fifo` is 0 and `tx_ready` is 0 once holding. When full drops, the push issues in that same cycle.
- **RX latency:** `fifo_empty` falls in cycle C, `read_fifo` high in C, byte captured at the end of C, `rx_valid` high in C+1. Sustained rate is 1 byte/clk with `rx_ready` held high.
- **Backpressure:** with `rx_ready=0`, at most 2 pops occur, then `read_fifo` stays 0 until a drain.
- All outputs except `write_fifo`, `read_fifo` and `tx_ready` are registered. Those three are one gate level from registers and the useq flags; there is no combinational path from `tx_valid` or `rx_ready` to any FIFO-port output.

## Structure
- Shared package `useq_pkg`:
  - `USEQ_DATA_W = 8`
  - the default for `CNT_W`
  - a stream byte typedef, also used by useq.
- Sub-module `useq_skid2`: the 2-entry RX skid buffer with in/out valid-ready ports and the occupancy output. It is reused by other useq bridges.
- The TX register, watchdog and counters live in the top.

## Test plan
Bench uses a behavioural useq FIFO model of depth 2 (registered full/empty).
1. **Reset mid-stream:** assert `rst` asynchronously between edges while TX holds 0xEE and RX has `occ=2`. All outputs reach reset values immediately, and 0xEE is never pushed.
2. **TX burst:** send 0xCC, 0xDD back-to-back with the model draining 1 byte/clk. Exactly two `write_fifo` pulses with `fifo_in` 0xCC then 0xDD, and `tx_count=2`.
3. **TX into full FIFO:** model never drains; send 0x11, 0x22, 0x33. Two pushes occur, 0x33 is held, `tx_ready=0`. With `STALL_CYCLES=4`, `tx_stall` rises 4 cycles after full blocks the push. Pulse `clr_stall` and `tx_stall` clears. Drain one entry, then 0x33 pushes, `tx_count=3`.
4. **RX with backpressure:** model holds 0xA1, 0xA2, 0xA3 and `rx_ready=0`. Exactly 2 pops occur, `rx_data=0xA1`. Release `rx_ready`: output is 0xA1, 0xA2, 0xA3 in order, `rx_count=3`.
5. **Full duplex:** simultaneous 8-byte TX (0x00..0x07) and 8-byte RX (0x80..0x87) streams complete with no loss or reordering, and both counts are 8.
6. **Counter wrap:** with `CNT_W=4`, 17 pushes give `tx_count=1`.
